hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of WAIT cycles before ERR (range 1..255).
REQ-002 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports ID_Rs1_i, ID_Rs2_i  in  5 each  source registers of the instruction in ID.
REQ-005 SHALL have port EX_MemRead_i  in  1  instruction in EX is a load.
REQ-006 SHALL have port EX_Rd_i  in  5  destination register of the instruction in EX.
REQ-007 SHALL have port Branch_taken_i  in  1  branch in ID resolved taken.
REQ-008 SHALL have port Mem_req_i  in  1  MEM-stage access needs an external memory transaction.
REQ-009 SHALL have port Mem_ack_i  in  1  external memory transaction done; valid only while requested.
REQ-010 SHALL have port PC_Write_o  out  1  PC update enable.
REQ-011 SHALL have port IFID_Write_o  out  1  IF/ID register update enable.
REQ-012 SHALL have port IFID_Flush_o  out  1  zero the IF/ID register.
REQ-013 SHALL have port IDEX_Bubble_o  out  1  insert a NOP into ID/EX.
REQ-014 SHALL have port Pipe_Stall_o  out  1  freeze all pipeline registers, including EX/MEM and MEM/WB.
REQ-015 SHALL have port Err_o  out  1  sticky memory-timeout error.
REQ-016 SHALL have ports Stall_cnt_o, Flush_cnt_o  out  16 each  performance counters.

Function
REQ-017 SHALL implement FSM states RUN, WAIT and ERR, held in a state register.
REQ-018 SHALL compute load-use hazard LU = EX_MemRead_i && EX_Rd_i!=0 && (EX_Rd_i==ID_Rs1_i || EX_Rd_i==ID_Rs2_i), combinationally.
REQ-019 SHALL compute memory stall MS = (RUN && Mem_req_i && !Mem_ack_i) || WAIT || ERR.
REQ-020 SHALL assert Pipe_Stall_o = MS, in the same cycle as the condition with zero latency.
REQ-021 SHALL, when MS=1, drive PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=0 and IFID_Flush_o=0 (freeze, no bubble, no flush).
REQ-022 SHALL, when MS=0 and LU=1, drive PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1 and IFID_Flush_o=0; load-use beats branch flush, since the branch re-resolves next cycle.
REQ-023 SHALL, when MS=0, LU=0 and Branch_taken_i=1, drive IFID_Flush_o=1 with PC_Write_o=1 and IFID_Write_o=1.
REQ-024 SHALL otherwise drive PC_Write_o=1, IFID_Write_o=1 and all other control outputs 0.
REQ-025 SHALL transition RUN->WAIT when Mem_req_i=1 and Mem_ack_i=0; an ack in the same cycle as the request causes no stall and no transition.
REQ-026 SHALL transition WAIT->RUN on the edge where Mem_ack_i=1; Pipe_Stall_o stays 1 during that ack cycle.
REQ-027 SHALL keep an 8-bit wait counter, cleared on entry to WAIT and incremented each WAIT cycle without ack.
REQ-028 SHALL transition WAIT->ERR when the wait counter reaches TIMEOUT with no ack.
REQ-029 SHALL hold ERR until reset, with Err_o=1 and Pipe_Stall_o=1; Mem_ack_i is ignored in ERR.
REQ-030 SHALL increment Stall_cnt_o once per cycle where Pipe_Stall_o or IDEX_Bubble_o is 1, saturating at 16'hFFFF.
REQ-031 SHALL increment Flush_cnt_o once per cycle where IFID_Flush_o=1, saturating at 16'hFFFF.
REQ-032 SHALL treat register x0 as never hazardous (EX_Rd_i=0 gives LU=0).

Reset
REQ-033 SHALL, while rst_i=1, force state to RUN, wait counter 0, Stall_cnt_o=0, Flush_cnt_o=0 and Err_o=0, asynchronously.
REQ-034 SHALL, while rst_i=1, drive PC_Write_o=0, IFID_Write_o=0, IFID_Flush_o=0, IDEX_Bubble_o=0 and Pipe_Stall_o=0.
REQ-035 SHALL, on reset asserted mid-WAIT or in ERR, abandon the transaction and resume in RUN on the first edge after deassertion.

Verification
REQ-036 SHALL test load-use: EX_MemRead_i=1, EX_Rd_i=5, ID_Rs2_i=5 -> PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1, Stall_cnt_o +1; with EX_Rd_i=0 -> no bubble.
REQ-037 SHALL test load-use plus branch: LU=1 and Branch_taken_i=1 together -> IDEX_Bubble_o=1, IFID_Flush_o=0, Flush_cnt_o unchanged.
REQ-038 SHALL test a memory wait: Mem_req_i=1, ack 3 cycles later -> Pipe_Stall_o=1 for 4 cycles, then RUN, Stall_cnt_o=4.
REQ-039 SHALL test a same-cycle ack: Mem_req_i=1 and Mem_ack_i=1 -> Pipe_Stall_o=0, state stays RUN.
REQ-040 SHALL test timeout with TIMEOUT=4: request, never ack -> Err_o=1 after the 4th WAIT cycle, sticky; a late ack is ignored; rst_i pulse clears it.
REQ-041 SHALL test saturation: preload Stall_cnt_o by 65535 bubbles, one more -> stays 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the pipeline-side signals of the hazard controller.
//   slave  : seen by hazard_ctrl (hazard inputs in, pipeline controls out)
//   master : seen by the pipeline / test environment (the reverse)
//
//   ID_Rs1_i, ID_Rs2_i : source registers of the instruction in ID
//   EX_MemRead_i       : instruction in EX is a load
//   EX_Rd_i            : destination register of the instruction in EX
//   Branch_taken_i     : branch in ID resolved taken
//   Mem_req_i          : MEM stage needs an external memory transaction
//   Mem_ack_i          : external transaction done (valid only while requested)
//   PC_Write_o         : PC update enable
//   IFID_Write_o       : IF/ID update enable
//   IFID_Flush_o       : zero IF/ID
//   IDEX_Bubble_o      : insert a NOP into ID/EX
//   Pipe_Stall_o       : freeze every pipeline register
//   Err_o              : sticky memory-timeout error
//   Stall_cnt_o        : stall/bubble cycle counter (saturating)
//   Flush_cnt_o        : flush cycle counter (saturating)
interface hazard_ctrl_if;
    logic [4:0]  ID_Rs1_i;
    logic [4:0]  ID_Rs2_i;
    logic        EX_MemRead_i;
    logic [4:0]  EX_Rd_i;
    logic        Branch_taken_i;
    logic        Mem_req_i;
    logic        Mem_ack_i;
    logic        PC_Write_o;
    logic        IFID_Write_o;
    logic        IFID_Flush_o;
    logic        IDEX_Bubble_o;
    logic        Pipe_Stall_o;
    logic        Err_o;
    logic [15:0] Stall_cnt_o;
    logic [15:0] Flush_cnt_o;

    modport slave (
        input  ID_Rs1_i, ID_Rs2_i, EX_MemRead_i, EX_Rd_i,
               Branch_taken_i, Mem_req_i, Mem_ack_i,
        output PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o,
               Pipe_Stall_o, Err_o, Stall_cnt_o, Flush_cnt_o
    );

    modport master (
        output ID_Rs1_i, ID_Rs2_i, EX_MemRead_i, EX_Rd_i,
               Branch_taken_i, Mem_req_i, Mem_ack_i,
        input  PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o,
               Pipe_Stall_o, Err_o, Stall_cnt_o, Flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller: load-use bubbles, taken-branch flushes and
//   whole-pipeline freezes while an external memory transaction is pending.
//   A memory transaction that is not acknowledged within TIMEOUT wait cycles
//   parks the controller in a sticky error state until reset.
//
//   Parameters
//     TIMEOUT : maximum WAIT cycles before ERR (1..255)
//   Ports
//     clk_i : clock, rising edge
//     rst_i : asynchronous active-high reset
//     bus   : hazard_ctrl_if.slave (hazard inputs, pipeline controls, counters)
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Wait count at which the last permitted WAIT cycle is being spent.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;
    logic        lu;
    logic        ms;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [15:0] stall_cnt, flush_cnt;

    // ------------------------------------------------------------------
    // State register and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            RUN: begin
                // A same-cycle ack completes the access without stalling.
                if (bus.Mem_req_i && !bus.Mem_ack_i) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            WAIT: begin
                if (bus.Mem_ack_i) begin
                    state_nxt = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ERR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard detection and pipeline controls
    // ------------------------------------------------------------------
    always_comb begin
        // x0 is hard-wired zero, so a load targeting it never creates a hazard.
        lu = bus.EX_MemRead_i && (bus.EX_Rd_i != 5'd0) &&
             ((bus.EX_Rd_i == bus.ID_Rs1_i) || (bus.EX_Rd_i == bus.ID_Rs2_i));
        ms = ((state == RUN) && bus.Mem_req_i && !bus.Mem_ack_i) ||
             (state != RUN);

        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        if (rst_i) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (ms) begin
            // Full freeze: nothing advances, nothing is squashed.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (lu) begin
            // Load-use wins over a taken branch; the branch re-resolves next cycle.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (bus.Branch_taken_i) begin
            ifid_flush = 1'b1;
        end
    end

    assign bus.PC_Write_o    = pc_write;
    assign bus.IFID_Write_o  = ifid_write;
    assign bus.IFID_Flush_o  = ifid_flush;
    assign bus.IDEX_Bubble_o = idex_bubble;
    assign bus.Pipe_Stall_o  = ms && !rst_i;
    assign bus.Err_o         = (state == ERR);

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((ms || idex_bubble) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (ifid_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

    assign bus.Stall_cnt_o = stall_cnt;
    assign bus.Flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk_i = ~clk_i;

    hazard_ctrl_if hif ();

    hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (hif)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic rd_mem, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic br, input logic req, input logic ack);
        hif.EX_MemRead_i   = rd_mem;
        hif.EX_Rd_i        = rd;
        hif.ID_Rs1_i       = rs1;
        hif.ID_Rs2_i       = rs2;
        hif.Branch_taken_i = br;
        hif.Mem_req_i      = req;
        hif.Mem_ack_i      = ack;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Combinational controls as {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Stall}
    function automatic logic [4:0] ctl();
        return {hif.PC_Write_o, hif.IFID_Write_o, hif.IFID_Flush_o,
                hif.IDEX_Bubble_o, hif.Pipe_Stall_o};
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        // Reset: everything low, counters cleared, even with a request present
        check("rst_ctl", ctl(), 5'b00000);
        check("rst_err", hif.Err_o, 0);
        check("rst_stall_cnt", hif.Stall_cnt_o, 0);
        check("rst_flush_cnt", hif.Flush_cnt_o, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        check("rst_req_nostall", ctl(), 5'b00000);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        #1;

        // Idle
        check("idle_ctl", ctl(), 5'b11000);
        tick();
        check("idle_stall_cnt", hif.Stall_cnt_o, 0);

        // Load-use on Rs2
        drive(1, 5, 3, 5, 0, 0, 0);
        check("lu_rs2_ctl", ctl(), 5'b00010);
        tick();
        check("lu_rs2_cnt", hif.Stall_cnt_o, 1);
        // Load-use on Rs1
        drive(1, 7, 7, 2, 0, 0, 0);
        check("lu_rs1_ctl", ctl(), 5'b00010);
        tick();
        check("lu_rs1_cnt", hif.Stall_cnt_o, 2);
        // Load to x0 never hazardous
        drive(1, 0, 0, 0, 0, 0, 0);
        check("lu_x0_ctl", ctl(), 5'b11000);
        tick();
        check("lu_x0_cnt", hif.Stall_cnt_o, 2);
        // Not a load
        drive(0, 5, 0, 5, 0, 0, 0);
        check("nolu_ctl", ctl(), 5'b11000);
        tick();

        // Taken branch only
        drive(0, 0, 0, 0, 1, 0, 0);
        check("br_ctl", ctl(), 5'b11100);
        tick();
        check("br_flush_cnt", hif.Flush_cnt_o, 1);

        // Load-use plus branch: bubble wins
        drive(1, 5, 0, 5, 1, 0, 0);
        check("lubr_ctl", ctl(), 5'b00010);
        tick();
        check("lubr_flush_cnt", hif.Flush_cnt_o, 1);
        check("lubr_stall_cnt", hif.Stall_cnt_o, 3);

        // Same-cycle ack: no stall, stays in RUN
        drive(0, 0, 0, 0, 0, 1, 1);
        check("ack0_ctl", ctl(), 5'b11000);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("ack0_run", ctl(), 5'b11000);
        check("ack0_cnt", hif.Stall_cnt_o, 3);

        // Memory wait, ack three cycles after the request
        drive(0, 0, 0, 0, 0, 1, 0);
        check("mw_c0", ctl(), 5'b00001);
        tick();
        drive(1, 5, 5, 0, 0, 1, 0);
        check("mw_c1_lu_frozen", ctl(), 5'b00001);
        tick();
        drive(0, 0, 0, 0, 1, 1, 0);
        check("mw_c2_br_frozen", ctl(), 5'b00001);
        tick();
        drive(0, 0, 0, 0, 0, 1, 1);
        check("mw_c3_ack", ctl(), 5'b00001);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("mw_run", ctl(), 5'b11000);
        check("mw_stall_cnt", hif.Stall_cnt_o, 7);
        check("mw_flush_cnt", hif.Flush_cnt_o, 1);

        // Timeout: request never acknowledged
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        check("to_enter_err", hif.Err_o, 0);
        for (int i = 1; i <= 4; i++) begin
            check("to_stall", ctl(), 5'b00001);
            tick();
            check($sformatf("to_err_w%0d", i), hif.Err_o, (i == 4) ? 1 : 0);
        end
        // Late ack is ignored
        drive(0, 0, 0, 0, 0, 0, 1);
        check("err_ack_ctl", ctl(), 5'b00001);
        tick();
        tick();
        check("err_sticky", hif.Err_o, 1);
        check("err_stall_cnt", hif.Stall_cnt_o, 14);
        // Asynchronous reset pulse clears it
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        #1;
        check("err_rst_err", hif.Err_o, 0);
        check("err_rst_cnt", hif.Stall_cnt_o, 0);
        check("err_rst_ctl", ctl(), 5'b00000);
        tick();
        rst_i = 1'b0;
        #1;
        check("err_rst_run", ctl(), 5'b11000);

        // Reset mid-WAIT abandons the transaction
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        check("midwait_stall", ctl(), 5'b00001);
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_i = 1'b0;
        #1;
        check("midwait_run", ctl(), 5'b11000);
        tick();
        check("midwait_run2", ctl(), 5'b11000);
        check("midwait_err", hif.Err_o, 0);

        // Saturation of the stall counter
        drive(1, 9, 9, 0, 0, 0, 0);
        repeat (65535) tick();
        check("sat_full", hif.Stall_cnt_o, 16'hFFFF);
        check("sat_bubble", ctl(), 5'b00010);
        tick();
        check("sat_hold", hif.Stall_cnt_o, 16'hFFFF);
        check("sat_flush_cnt", hif.Flush_cnt_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
